// File: rtl/wddl_xor3_sequencer.sv
// Precharge/evaluate sequencer for a 3-input WDDL word XOR datapath. It buffers one pending job
// and flags (sticky) any captured result whose rails are not complementary.
module wddl_xor3_sequencer #(
   parameter int unsigned WORD        = 32,
   parameter int unsigned PRE_CYCLES  = 1,
   parameter int unsigned EVAL_CYCLES = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [WORD-1:0] a_t_i,
   input  logic [WORD-1:0] a_f_i,
   input  logic [WORD-1:0] b_t_i,
   input  logic [WORD-1:0] b_f_i,
   input  logic [WORD-1:0] c_t_i,
   input  logic [WORD-1:0] c_f_i,
   output logic [WORD-1:0] dp_in1_t_o,
   output logic [WORD-1:0] dp_in1_f_o,
   output logic [WORD-1:0] dp_in2_t_o,
   output logic [WORD-1:0] dp_in2_f_o,
   output logic [WORD-1:0] dp_in3_t_o,
   output logic [WORD-1:0] dp_in3_f_o,
   input  logic [WORD-1:0] dp_out_t_i,
   input  logic [WORD-1:0] dp_out_f_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [WORD-1:0] res_t_o,
   output logic [WORD-1:0] res_f_o,
   output logic            fault_o
);

   localparam int unsigned CntMax = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
   localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);
   localparam logic [CntW-1:0] PreLast  = CntW'(PRE_CYCLES - 1);
   localparam logic [CntW-1:0] EvalLast = CntW'(EVAL_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StPre, StEval, StOut} state_e;

   state_e                   state_q;
   logic [CntW-1:0]          cnt_q;
   logic                     in_ready_q;
   logic                     pend_q;
   logic                     out_valid_q;
   logic                     fault_q;
   logic [2:0][WORD-1:0]     op_t_q;
   logic [2:0][WORD-1:0]     op_f_q;
   logic [2:0][WORD-1:0]     dp_t_q;
   logic [2:0][WORD-1:0]     dp_f_q;
   logic [WORD-1:0]          res_t_q;
   logic [WORD-1:0]          res_f_q;
   logic                     accept;

   // in_ready_q is only ever high in StIdle and StOut, so accept implies one of those states.
   assign accept = in_valid_i & in_ready_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         pend_q      <= 1'b0;
         out_valid_q <= 1'b0;
         fault_q     <= 1'b0;
         op_t_q      <= '0;
         op_f_q      <= '0;
         dp_t_q      <= '0;
         dp_f_q      <= '0;
         res_t_q     <= '0;
         res_f_q     <= '0;
      end else begin
         if (accept) begin
            op_t_q <= {c_t_i, b_t_i, a_t_i};
            op_f_q <= {c_f_i, b_f_i, a_f_i};
         end
         unique case (state_q)
            StIdle: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  in_ready_q <= 1'b0;
                  cnt_q      <= '0;
                  state_q    <= StPre;
               end
            end
            StPre: begin
               if (cnt_q == PreLast) begin
                  cnt_q   <= '0;
                  dp_t_q  <= op_t_q;
                  dp_f_q  <= op_f_q;
                  state_q <= StEval;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StEval: begin
               if (cnt_q == EvalLast) begin
                  cnt_q       <= '0;
                  res_t_q     <= dp_out_t_i;
                  res_f_q     <= dp_out_f_i;
                  // Any rail pair reading 00 or 11 marks a fault or glitch in the datapath.
                  if ((dp_out_t_i ^ dp_out_f_i) != '1) fault_q <= 1'b1;
                  dp_t_q      <= '0;
                  dp_f_q      <= '0;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b1;
                  state_q     <= StOut;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StOut: begin
               if (accept) begin
                  pend_q     <= 1'b1;
                  in_ready_q <= 1'b0;
               end
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  res_t_q     <= '0;
                  res_f_q     <= '0;
                  pend_q      <= 1'b0;
                  if (pend_q || accept) begin
                     in_ready_q <= 1'b0;
                     state_q    <= StPre;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= StIdle;
                  end
               end
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign fault_o     = fault_q;
   assign res_t_o     = res_t_q;
   assign res_f_o     = res_f_q;
   assign dp_in1_t_o  = dp_t_q[0];
   assign dp_in1_f_o  = dp_f_q[0];
   assign dp_in2_t_o  = dp_t_q[1];
   assign dp_in2_f_o  = dp_f_q[1];
   assign dp_in3_t_o  = dp_t_q[2];
   assign dp_in3_f_o  = dp_f_q[2];

endmodule
